sd_spi: RTL
===========

# sd_spi

SPI master for the SD card, sitting directly downstream of the memory/port mapper. It consumes the mapper's one-cycle `sd_signal` strobe, 2-bit `sd_cmd` and `sd_out` byte. It drives the card's SPI pins and returns the received byte, a busy flag and a timeout flag, which the mapper presents to the CPU on ports 0Fh and 1Fh.

## Interface
- `SPI_DIV`, default 32: system clocks per SCLK half-period (≥1); 25 MHz / 64 ≈ 390 kHz, valid for SD init.
- `TIMEOUT_CYCLES`, default 25_000_000: clocks after the last accepted command before `sd_timeout` asserts.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sd_signal`  in  1  command strobe, one cycle high.
- `sd_cmd`  in  2  command: 0 = init, 1 = byte exchange, 2 = CS assert (low), 3 = CS deassert (high).
- `sd_out`  in  8  byte to transmit for cmd 1.
- `sd_din`  out  8  last received byte.
- `sd_busy`  out  1  =1 while init or exchange runs.
- `sd_timeout`  out  1  =1 once `TIMEOUT_CYCLES` have elapsed since the last accepted command.
- `spi_cs`  out  1  card chip select, active low.
- `spi_sclk`  out  1  SPI clock, mode 0 (idle low).
- `spi_mosi`  out  1  master out.
- `spi_miso`  in  1  master in; bench drives it synchronously.

## Operation
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=1, `sd_din`=FFh, `sd_busy`=0, `sd_timeout`=0, state IDLE, timeout counter 0.
- States: IDLE, INIT, XFER.
- A command is accepted only when `sd_signal`=1 in IDLE. A strobe while INIT or XFER is active is ignored entirely, including `sd_out`, CS and the timeout counter.
- cmd 0, IDLE→INIT:
  - `spi_cs` forced 1 and `spi_mosi` held 1.
  - 80 full SCLK periods (160 half-periods).
  - Then return to IDLE; `spi_cs` stays 1; `sd_din` unchanged.
- cmd 1, IDLE→XFER:
  - Load shift register with `sd_out`; `spi_mosi` = `sd_out[7]` on the acceptance edge. MSB first, mode 0.
  - On each rising SCLK toggle, shift `spi_miso` into the receive LSB.
  - On each falling toggle, present the next TX bit.
  - After the 8th falling toggle: `sd_din` ← received byte, `spi_mosi` ← 1, return to IDLE.
  - `spi_cs` is not touched.
- cmd 2: `spi_cs` ← 0. cmd 3: `spi_cs` ← 1. Both complete in the accepting cycle, with no busy and no SCLK activity.
- `sd_busy` = 1 exactly while the state is INIT or XFER.
- Timeout counter:
  - Cleared on every accepted command.
  - Otherwise increments each cycle, saturating at `TIMEOUT_CYCLES`.
  - `sd_timeout` = (counter == `TIMEOUT_CYCLES`).
  - Counter width is ceil(log2(`TIMEOUT_CYCLES`+1)); no wrap.
- Half-period counter runs 0..`SPI_DIV`-1. It is cleared on command acceptance; at `SPI_DIV`-1 it wraps to 0 and SCLK toggles.
- Reset mid-transfer aborts immediately to reset values. `sd_din` returns to FFh; no partial byte is kept.

## Timing
- Command accepted at edge N, with `sd_signal` sampled high. From edge N, `sd_busy` = 1 (INIT/XFER) or `spi_cs` is updated (cmd 2/3).
- First SCLK rise at edge N+`SPI_DIV`.
- XFER:
  - 8 periods = 16·`SPI_DIV` clocks.
  - At edge N+16·`SPI_DIV`: `sd_busy` falls and `sd_din` is valid, in the same cycle. `spi_sclk` is back at 0.
- INIT: `sd_busy` falls at edge N+160·`SPI_DIV`.
- MISO is sampled on the clock edge at which SCLK rises, using the value present before that edge.
- A new strobe is accepted in the same cycle `sd_busy` reads 0.
- The mapper's strobe arrives one cycle after the CPU OUT. The CPU polls busy via port 1Fh, so it needs no further margin.

## Test plan
- Reset: pulse `reset` for 2 cycles -> `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=1, `sd_din`=FFh, `sd_busy`=0, `sd_timeout`=0.
- Exchange, `SPI_DIV`=2:
  - Stimulus: cmd 2, then cmd 1 with `sd_out`=3Ch; MISO model returns A5h.
  - Required: `spi_cs`=0; MOSI bits 0,0,1,1,1,1,0,0 on successive SCLK rises; `sd_busy` high for exactly 32 cycles; then `sd_din`=A5h.
- Init, `SPI_DIV`=2: cmd 0 -> exactly 80 SCLK rising edges with `spi_cs`=1 and `spi_mosi`=1 throughout; `sd_busy` high for exactly 320 cycles; `sd_din` unchanged.
- Strobe while busy: during an exchange of 3Ch, pulse cmd 3 and cmd 1 with `sd_out`=FFh -> ignored; `spi_cs` stays 0, transmitted byte stays 3Ch, busy duration unchanged.
- Timeout, `TIMEOUT_CYCLES`=100:
  - Accept cmd 2 -> `sd_timeout` rises exactly 100 cycles later and stays high.
  - A further cmd 3 clears it the following cycle.
- Reset mid-XFER: assert `reset` after 3 SCLK periods -> next cycle `sd_busy`=0, `spi_cs`=1, `spi_sclk`=0, `sd_din`=FFh. A following cmd 1 exchange completes normally.

Source files
------------

// File: rtl/sd_spi.sv
// sd_spi: SPI master (mode 0) for the SD card, with init clocking, byte exchange, CS control and an idle timeout.
module sd_spi #(
  parameter int SPI_DIV        = 32,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = SPI_DIV > 1 ? $clog2(SPI_DIV) : 1;
  typedef enum logic [1:0] {IDLE, INIT, XFER} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [7:0] half_cnt, tx, rx;
  logic [TW-1:0] to_cnt;
  logic accept, tick, last;
  assign accept = sd_signal && state == IDLE;
  assign tick = state != IDLE && div_cnt == DW'(SPI_DIV - 1);
  // INIT runs 160 half-periods, XFER runs 16
  assign last = tick && half_cnt == (state == INIT ? 8'd159 : 8'd15);
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = accept ? (sd_cmd == 2'd0 ? INIT : sd_cmd == 2'd1 ? XFER : IDLE)
                      : (last ? IDLE : state);
  end
  always_comb begin
    sd_busy = state != IDLE;
    sd_timeout = to_cnt == TW'(TIMEOUT_CYCLES);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      spi_cs <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
      sd_din <= 8'hff;
      div_cnt <= '0;
      half_cnt <= '0;
      tx <= '0;
      rx <= '0;
      to_cnt <= '0;
    end else begin
      to_cnt <= accept ? '0 : (sd_timeout ? to_cnt : to_cnt + 1'b1);
      if (accept) begin
        div_cnt <= '0;
        half_cnt <= '0;
        spi_cs <= sd_cmd == 2'd2 ? 1'b0 : (sd_cmd == 2'd1 ? spi_cs : 1'b1);
        spi_mosi <= sd_cmd == 2'd1 ? sd_out[7] : (sd_cmd == 2'd0 ? 1'b1 : spi_mosi);
        tx <= sd_cmd == 2'd1 ? sd_out : tx;
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          spi_sclk <= ~spi_sclk;
          half_cnt <= half_cnt + 8'd1;
          if (state == XFER) begin
            if (!spi_sclk) rx <= {rx[6:0], spi_miso};
            else if (last) begin
              sd_din <= rx;
              spi_mosi <= 1'b1;
            end else begin
              spi_mosi <= tx[6];
              tx <= {tx[6:0], 1'b0};
            end
          end
        end
      end
    end
  end
endmodule
